// File: rtl/ram_sync_param.sv
// Clocked single-port RAM with a configurable read latency, an optional clear sweep
// after reset, and a shared data bus that is driven only while a read result is valid.
module ram_sync_param #(
    parameter int              DATA_W         = 4,
    parameter int              ADDR_W         = 12,
    parameter int              DEPTH          = 4096,
    parameter int              READ_LAT       = 1,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csRAM,
    input  logic              weRAM,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              rvalid
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 cnt_q, cnt_d;
    logic                             ready_q;
    logic [READ_LAT-1:0]              vld_q;
    logic [READ_LAT-1:0][DATA_W-1:0]  dat_q;

    logic              in_range, wr_acc, rd_acc, mem_we;
    logic [IDX_W-1:0]  idx, mem_idx;
    logic [DATA_W-1:0] mem_wd, rd_word;

    assign in_range = ({1'b0, address} < DEPTH_C);
    assign idx      = address[IDX_W-1:0];
    // ready_q is only ever set while in RUN, so it doubles as the access qualifier
    assign wr_acc   = ready_q & csRAM & weRAM & in_range;
    assign rd_acc   = ready_q & csRAM & ~weRAM;
    assign rd_word  = in_range ? mem[idx] : '0;

    // Gate with rst_n so a CLEAR reset state cannot write while reset is held
    assign mem_we  = rst_n & ((state_q == CLEAR) | wr_acc);
    assign mem_idx = (state_q == CLEAR) ? cnt_q : idx;
    assign mem_wd  = (state_q == CLEAR) ? INIT_VAL : data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            vld_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= (state_d == RUN);
            vld_q[0] <= rd_acc;
            dat_q[0] <= rd_word;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Array has no reset so contents survive reset when the sweep is disabled
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wd;
    end

    assign ready  = ready_q;
    assign rvalid = vld_q[READ_LAT-1];
    assign data   = rvalid ? dat_q[READ_LAT-1] : {DATA_W{1'bz}};

endmodule

// File: doc/ram_sync_param.md
Name: ram_sync_param

Overview:
- Parametrised, clocked single-port RAM for the 4-bit CPU datapath. Next generation of the asynchronous cs/we RAM.
- Configurable data width, address width, depth and read latency.
- Optional hardware clear sweep after reset, with a ready flag.
- Keeps the shared bidirectional data bus, now driven only while a read result is valid.

Parameters:
- DATA_W, 4: data word width in bits.
- ADDR_W, 12: address width in bits.
- DEPTH, 4096: number of words; must be 2 or more and at most 2**ADDR_W.
- READ_LAT, 1: read latency in clocks; legal values 1 or 2.
- CLEAR_ON_RESET, 1: 1 = sweep INIT_VAL into every word after reset; 0 = contents retained across reset.
- INIT_VAL, 0: DATA_W-bit value written by the clear sweep.

Ports:
- clk, input, 1: system clock; everything is rising-edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- csRAM, input, 1: chip select, sampled on the clk rising edge.
- weRAM, input, 1: 1 = write, 0 = read; qualified by csRAM.
- address, input, ADDR_W: word address, sampled with csRAM.
- data, inout, DATA_W: shared bus. Master drives it on write cycles. RAM drives it only while rvalid=1, otherwise high-Z.
- ready, output, 1: 1 = accesses accepted; 0 = clear sweep in progress.
- rvalid, output, 1: read data is valid on data this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ready=0, rvalid=0, data=Z.
  - Read pipeline emptied; sweep counter=0.
  - Memory array is not reset directly.
- FSM states: CLEAR and RUN.
  - On reset release: CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR writes INIT_VAL to memory[cnt] each clock, cnt 0 up to DEPTH-1.
  - Transition: on the edge that writes DEPTH-1, next state is RUN and ready=1 from the following cycle. The sweep takes exactly DEPTH clocks.
  - CLEAR ignores csRAM/weRAM completely: no writes, no reads, rvalid stays 0.
  - rst_n asserted mid-sweep aborts it. After release the sweep restarts at address 0.
- Write (RUN, csRAM=1, weRAM=1 at an edge): memory[address] <= data at that edge. No response signal.
- Read (RUN, csRAM=1, weRAM=0 at edge N):
  - READ_LAT=1: rvalid=1 and data=memory[address] during cycle N+1.
  - READ_LAT=2: the same, during cycle N+2.
  - rvalid is a one-cycle pulse per accepted read.
  - Back-to-back reads are allowed every clock: fully pipelined, one result per cycle.
- Read-after-write to the same address on consecutive edges returns the newly written value.
- csRAM=0: no access; pipeline keeps draining already-accepted reads.
- Out-of-range address (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - write is dropped;
  - read still produces an rvalid pulse with data = 0.
- Bus turnaround:
  - RAM drives data only in rvalid cycles.
  - The master must not drive data in the READ_LAT cycles after a read.
  - A write accepted in a cycle where rvalid=1 is a master protocol error; the outcome is undefined and is checked as an assertion by verification.
- rst_n asserted with reads in flight: pending results are discarded, with no rvalid after release.
- Memory contents when CLEAR_ON_RESET=0: unchanged by reset; previously written data is readable after release.
- X-safety: rvalid and ready never X after the first reset.

Test Plan:
- Reset then release, CLEAR_ON_RESET=1, DEPTH=16, INIT_VAL=4'hA:
  - ready=0 for exactly 16 clocks, then 1;
  - reads of all 16 addresses return 4'hA.
- READ_LAT=1: write 4'hF to addr 0, then 4'h3 to addr 12'hFFF; read 0 then FFF on consecutive edges -> rvalid on two consecutive cycles with data F then 3; data=Z in every other cycle.
- READ_LAT=2: write 4'h5 to addr 7 at edge N, read addr 7 at edge N+1 -> rvalid=1 and data=4'h5 exactly at cycle N+3.
- Mid-sweep reset: pulse rst_n low at sweep cnt=9 of 16 -> after release, ready stays 0 for a full 16 clocks; a write attempted during the sweep is absent afterwards (reads INIT_VAL).
- CLEAR_ON_RESET=0: write 4'h9 to addr 2, then reset -> ready=1 on the first clock after release; read addr 2 returns 4'h9.
- DEPTH=12, ADDR_W=4: write 4'h7 to addr 13 -> dropped; read addr 13 returns rvalid with data 0. Also issue a read, then assert reset before rvalid -> no rvalid after release.
